// File: rtl/tastensender_if.sv
// Request/status bundle between a press-train requester and tastensender.
// The requester drives start/anzahl; the generator drives the rest.
interface tastensender_if;
  logic       start;
  logic [3:0] anzahl;
  logic       taste;
  logic       busy;
  logic       done;
  logic [3:0] sent;

  modport master (
    output start,
    output anzahl,
    input  taste,
    input  busy,
    input  done,
    input  sent
  );

  modport slave (
    input  start,
    input  anzahl,
    output taste,
    output busy,
    output done,
    output sent
  );
endinterface

// File: rtl/tastensender.sv
// Button-press train generator: emits anzahl high/low pulses on taste,
// then a one-cycle done pulse. All outputs come straight from flops.
module tastensender #(
  parameter int HIGH_CYCLES = 1000,
  parameter int LOW_CYCLES  = 1000
) (
  input logic           clk,
  input logic           reset,
  tastensender_if.slave bus
);

  localparam int MAX_LEN =
    (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CW = $clog2(MAX_LEN + 1);

  localparam logic [CW-1:0] H_LAST = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] L_LAST = CW'(LOW_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    FIN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    rem;
  logic          taste_q;
  logic          busy_q;
  logic          done_q;
  logic [3:0]    sent_q;

  // Train sequencer: phase timing, press bookkeeping and registered outputs.
  // FIN entered from IDLE (anzahl==0) first spends a busy cycle with done
  // low, then raises done; FIN entered from LOW raises done immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rem     <= '0;
      taste_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sent_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          taste_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          cnt     <= '0;
          if (bus.start) begin
            rem    <= bus.anzahl;
            sent_q <= '0;
            busy_q <= 1'b1;
            if (bus.anzahl != 4'd0) begin
              state   <= HIGH;
              taste_q <= 1'b1;
            end else begin
              state <= FIN;
            end
          end
        end

        HIGH: begin
          if (cnt == H_LAST) begin
            cnt     <= '0;
            taste_q <= 1'b0;
            state   <= LOW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        LOW: begin
          if (cnt == L_LAST) begin
            cnt    <= '0;
            sent_q <= sent_q + 4'd1;
            rem    <= rem - 4'd1;
            if (rem == 4'd1) begin
              state  <= FIN;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state   <= HIGH;
              taste_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        FIN: begin
          cnt <= '0;
          if (!done_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            done_q <= 1'b0;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.taste = taste_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sent  = sent_q;

endmodule

// File: tb/tb_tastensender.sv
// Scoreboard bench for tastensender: per-cycle expected outputs are queued
// when a request is issued and compared as the DUT runs.
module tb_tastensender;

  localparam int HC = 4;
  localparam int LC = 3;

  logic clk = 1'b0;
  logic rst;

  int n_run  = 0;
  int n_fail = 0;

  logic [6:0] exp_q[$];

  tastensender_if bus ();
  tastensender_if bus2 ();

  tastensender #(
    .HIGH_CYCLES(HC),
    .LOW_CYCLES (LC)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus.slave)
  );

  tastensender #(
    .HIGH_CYCLES(40),
    .LOW_CYCLES (40)
  ) dut_lb (
    .clk  (clk),
    .reset(rst),
    .bus  (bus2.slave)
  );

  always #5 clk = ~clk;

  // Loopback receiver: debounce taste, count rising edges of the clean line.
  logic       ent;
  logic       ent_q;
  logic [4:0] dcnt;
  int         pcount;

  always @(posedge clk) begin
    if (rst) begin
      ent    <= 1'b0;
      ent_q  <= 1'b0;
      dcnt   <= '0;
      pcount <= 0;
    end else begin
      ent_q <= ent;
      if (ent && !ent_q) pcount <= pcount + 1;
      if (bus2.taste != ent) begin
        if (dcnt == 5'd15) begin
          ent  <= bus2.taste;
          dcnt <= '0;
        end else begin
          dcnt <= dcnt + 5'd1;
        end
      end else begin
        dcnt <= '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] obs();
    return {bus.taste, bus.busy, bus.done, bus.sent};
  endfunction

  // Expected trace {taste,busy,done,sent} from the cycle after acceptance,
  // including one trailing idle cycle.
  task automatic push_req(input int n);
    if (n == 0) begin
      exp_q.push_back({1'b0, 1'b1, 1'b0, 4'd0});
      exp_q.push_back({1'b0, 1'b0, 1'b1, 4'd0});
    end else begin
      for (int p = 0; p < n; p++) begin
        for (int h = 0; h < HC; h++)
          exp_q.push_back({1'b1, 1'b1, 1'b0, 4'(p)});
        for (int l = 0; l < LC; l++)
          exp_q.push_back({1'b0, 1'b1, 1'b0, 4'(p)});
      end
      exp_q.push_back({1'b0, 1'b0, 1'b1, 4'(n)});
    end
    exp_q.push_back({1'b0, 1'b0, 1'b0, 4'(n)});
  endtask

  task automatic go(input int n);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.anzahl = 4'(n);
    push_req(n);
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.anzahl = 4'($urandom_range(15));
  endtask

  task automatic consume(input int k, input int inj, input string tag);
    logic [6:0] e;
    for (int i = 0; i < k; i++) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_underflow"}, 32'd0, 32'd1);
        return;
      end
      e = exp_q.pop_front();
      chk(tag, 32'(obs()), 32'(e));
      if (i == inj) begin
        bus.start  = 1'b1;
        bus.anzahl = 4'd7;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
  endtask

  initial begin
    int t;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.anzahl  = 4'd0;
    bus2.start  = 1'b0;
    bus2.anzahl = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(obs()), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset during HIGH of press 2
    go(3);
    consume(HC + LC + 2, -1, "pre_rst");
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("in_rst", 32'(obs()), 32'd0);
    end
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst", 32'(obs()), 32'd0);
    end

    go(3);
    consume(3 * (HC + LC) + 2, -1, "n3");

    go(0);
    consume(3, -1, "n0");

    go(2);
    consume(2 * (HC + LC) + 2, 2, "ign_start");

    go(15);
    consume(15 * (HC + LC) + 2, -1, "n15");

    // Back-to-back: start on the cycle right after FIN
    go(1);
    consume(HC + LC + 1, -1, "b2b_a");
    exp_q.delete();
    go(1);
    consume(HC + LC + 2, -1, "b2b_b");

    // Loopback through debouncer and press counter
    @(negedge clk);
    bus2.start  = 1'b1;
    bus2.anzahl = 4'd5;
    @(posedge clk);
    #1;
    bus2.start = 1'b0;
    t = 0;
    while (!bus2.done && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 1000) chk("lb_timeout", 32'd0, 32'd1);
    chk("lb_count", 32'(pcount), 32'd5);
    chk("lb_sent", 32'(bus2.sent), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
